// File: rtl/vga_pkg.sv
// vga_pkg: screen and paddle geometry shared by the paddle, ball and renderer blocks, plus the paddle clamp helper
package vga_pkg;
  localparam int RECT_X_POSITION = 20;
  localparam int RECT_WIDTH = 10;
  localparam int RECT_HEIGHT = 100;
  localparam int VER_PIXELS = 600;
  localparam int PADDLE_Y_MAX = VER_PIXELS - RECT_HEIGHT;
  function automatic logic [10:0] clamp_y(input logic signed [11:0] v, input int lo, input int hi);
    return (v < lo) ? 11'(lo) : (v > hi) ? 11'(hi) : 11'(v);
  endfunction
endpackage

// File: rtl/paddle_ctl_btn_debounce.sv
// btn_debounce: 2-FF synchroniser then stability counter; ports clk, rst, btn_raw (async in), btn_db (debounced level)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 400_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      btn_db <= 1'b0;
    end else begin
      sync <= {sync[0], btn_raw};
      if (sync[1] == btn_db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        btn_db <= ~btn_db;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/paddle_ctl.sv
// paddle_ctl: buttons btn_up/btn_down -> debounced, tick-stepped, accelerating paddle position rect_y_pos with at_top/at_bottom flags
module paddle_ctl
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 400_000,
  parameter int STEP_CYCLES = 200_000,
  parameter int RAMP_STEPS = 16,
  parameter int SPEED_MAX = 4,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = PADDLE_Y_MAX,
  parameter int Y_INIT = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [10:0] rect_y_pos,
  output logic        at_top,
  output logic        at_bottom
);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  localparam int TW = $clog2(STEP_CYCLES + 1);
  localparam int RW = $clog2(RAMP_STEPS + 1);
  localparam int SW = $clog2(SPEED_MAX + 1);
  logic u, d, tick, entering;
  state_t state, state_nxt;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] ramp, ramp_base, ramp_inc, ramp_nxt;
  logic [SW-1:0] speed, spd_base, speed_nxt;
  logic signed [11:0] y_s, spd_s;
  logic [10:0] y_nxt;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (.clk(clk), .rst(rst), .btn_raw(btn_up), .btn_db(u));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (.clk(clk), .rst(rst), .btn_raw(btn_down), .btn_db(d));
  // the move on a tick follows state_nxt, so a direction change landing on a tick already moves at speed 1
  always_comb begin
    tick = tcnt == TW'(STEP_CYCLES - 1);
    state_nxt = (u & ~d) ? UP : (d & ~u) ? DOWN : IDLE;
    entering = state_nxt != state;
    spd_base = entering ? SW'(1) : speed;
    ramp_base = entering ? '0 : ramp;
    ramp_inc = ramp_base + 1'b1;
    ramp_nxt = (state_nxt == IDLE) ? '0 : !tick ? ramp_base : (ramp_inc == RW'(RAMP_STEPS)) ? '0 : ramp_inc;
    speed_nxt = (state_nxt == IDLE) ? '0
              : (tick && ramp_inc == RW'(RAMP_STEPS) && spd_base != SW'(SPEED_MAX)) ? spd_base + 1'b1 : spd_base;
    y_s = 12'(rect_y_pos);
    spd_s = 12'(spd_base);
    y_nxt = (tick && state_nxt == UP) ? clamp_y(y_s - spd_s, Y_MIN, Y_MAX)
          : (tick && state_nxt == DOWN) ? clamp_y(y_s + spd_s, Y_MIN, Y_MAX) : rect_y_pos;
  end
  always_ff @(posedge clk)
    if (rst) begin
      tcnt <= '0;
      state <= IDLE;
      ramp <= '0;
      speed <= '0;
      rect_y_pos <= 11'(Y_INIT);
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      state <= state_nxt;
      ramp <= ramp_nxt;
      speed <= speed_nxt;
      rect_y_pos <= y_nxt;
    end
  assign at_top = rect_y_pos == 11'(Y_MIN);
  assign at_bottom = rect_y_pos == 11'(Y_MAX);
endmodule

// File: tb/tb_paddle_ctl.sv
// tb_paddle_ctl: scoreboard bench for paddle_ctl with short debounce/tick parameters
module tb_paddle_ctl;
  localparam int YMAX = 500;
  localparam int YINIT = 250;
  logic clk = 1'b0, rst = 1'b1, btn_up = 1'b0, btn_down = 1'b0;
  logic [10:0] rect_y_pos;
  logic at_top, at_bottom;
  logic mon_en = 1'b0;
  logic [10:0] prev;
  int checks = 0, errors = 0;
  int exp_q[$];
  always #5 clk = ~clk;
  paddle_ctl #(
    .DEBOUNCE_CYCLES(4), .STEP_CYCLES(10), .RAMP_STEPS(2), .SPEED_MAX(3),
    .Y_MIN(0), .Y_MAX(YMAX), .Y_INIT(YINIT)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .rect_y_pos(rect_y_pos), .at_top(at_top), .at_bottom(at_bottom)
  );
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  always @(negedge clk)
    if (mon_en && rect_y_pos !== prev) begin
      int e;
      if (exp_q.size() == 0) check("unexpected_move", int'(rect_y_pos), int'(prev));
      else begin
        e = exp_q.pop_front();
        check("pos", int'(rect_y_pos), e);
        check("at_top", int'(at_top), int'(e == 0));
        check("at_bottom", int'(at_bottom), int'(e == YMAX));
      end
      prev = rect_y_pos;
    end
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_run(input int y0, input int dir, input int n, output int yf);
    int y = y0, k = 0, spd;
    while ((n == 0) ? (y != ((dir > 0) ? YMAX : 0)) : (k < n)) begin
      spd = (1 + k / 2 > 3) ? 3 : 1 + k / 2;
      y = y + dir * spd;
      y = (y < 0) ? 0 : (y > YMAX) ? YMAX : y;
      exp_q.push_back(y);
      k++;
    end
    yf = y;
  endtask
  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    int y, n;
    cycles(3);
    rst = 1'b0;
    check("reset_pos", int'(rect_y_pos), YINIT);
    check("reset_top", int'(at_top), 0);
    check("reset_bottom", int'(at_bottom), 0);
    prev = 11'(YINIT);
    mon_en = 1'b1;
    btn_up = 1'b1;
    cycles(3);
    btn_up = 1'b0;
    cycles(100);
    check("glitch_hold", int'(rect_y_pos), YINIT);
    btn_down = 1'b1;
    push_run(YINIT, 1, 0, y);
    wait_empty("down_run", 2000);
    cycles(50);
    check("clamp_bottom_pos", int'(rect_y_pos), YMAX);
    check("clamp_bottom_flag", int'(at_bottom), 1);
    btn_down = 1'b0;
    cycles(20);
    btn_up = 1'b1;
    push_run(YMAX, -1, 0, y);
    wait_empty("up_run", 4000);
    cycles(50);
    check("clamp_top_pos", int'(rect_y_pos), 0);
    check("clamp_top_flag", int'(at_top), 1);
    btn_up = 1'b0;
    cycles(20);
    exp_q.push_back(YINIT);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("rst_idle_pos", int'(rect_y_pos), YINIT);
    btn_up = 1'b1;
    btn_down = 1'b1;
    cycles(100);
    check("both_hold", int'(rect_y_pos), YINIT);
    exp_q.push_back(249);
    exp_q.push_back(248);
    btn_down = 1'b0;
    wait_empty("up_after_both", 100);
    btn_up = 1'b0;
    cycles(20);
    check("up_after_both_pos", int'(rect_y_pos), 248);
    btn_down = 1'b1;
    push_run(248, 1, 7, y);
    wait_empty("down_before_rst", 300);
    exp_q.push_back(YINIT);
    exp_q.push_back(YINIT + 1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("rst_mid_move_pos", int'(rect_y_pos), YINIT);
    n = 0;
    while (rect_y_pos != 11'(YINIT + 1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("resume_latency", n, 10);
    btn_down = 1'b0;
    wait_empty("resume", 50);
    cycles(30);
    check("final_pos", int'(rect_y_pos), YINIT + 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
